// File: rtl/sdm_div_pkg.sv
// Shared constants for the fractional-N divider loop.
//   ORDER_MAX     number of MASH accumulator stages
//   Y_W           nominal width of the signed modulator output
//   LFSR_*        dither generator shape (x^15 + x^14 + 1)
//   order_e       encoding of the 'order' control input
package sdm_div_pkg;

  localparam int ORDER_MAX = 3;
  localparam int Y_W       = 3;

  localparam int                LFSR_W    = 15;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;

  typedef enum logic [1:0] {
    ORD_INT  = 2'd0,
    ORD_M1   = 2'd1,
    ORD_M11  = 2'd2,
    ORD_M111 = 2'd3
  } order_e;

endpackage

// File: rtl/sdm_mash_stage.sv
// One MASH accumulator stage: FRAC_W-bit wrapping accumulator.
//   clk, rst  clock / synchronous active-high reset
//   en        advance the accumulator (once per output period)
//   clr       stage disabled: outputs forced to zero, accumulator cleared on en
//   addend    value added this update (frac or previous stage's new value)
//   cin       carry-in LSB (dither bit on stage 1)
//   acc_nxt   accumulator value after this update (feeds the next stage)
//   cout      carry out of this update
module sdm_mash_stage #(
  parameter int FRAC_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [FRAC_W-1:0] addend,
  input  logic              cin,
  output logic [FRAC_W-1:0] acc_nxt,
  output logic              cout
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  always_comb begin
    sum = {1'b0, acc} + {1'b0, addend} + {{FRAC_W{1'b0}}, cin};
  end

  assign acc_nxt = clr ? '0   : sum[FRAC_W-1:0];
  assign cout    = clr ? 1'b0 : sum[FRAC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/sdm_div_loop_p.sv
// Fractional-N divider loop: a MASH-1/1-1/1-1-1 modulator dithers a
// multi-modulus counter so the average ratio is N + frac/2^FRAC_W.
//   clk, rst   clock / synchronous active-high reset
//   N, frac    integer ratio and fractional word (sampled at period start)
//   order      0 integer, 1..3 MASH order (sampled at period start)
//   sdm_mpr_o  modulus of the current output period
//   clko/clkob divided clock pair, high for ceil(M/2) clks
//   sdm_qn     stage-1 carry of the last modulator update
//   div_tick   pulse on the last clk of each output period
// Optional: define SDM_DITHER_EN to add an LFSR bit as carry-in to stage 1.
module sdm_div_loop_p
  import sdm_div_pkg::*;
#(
  parameter int N_W     = 6,
  parameter int FRAC_W  = 10,
  parameter int MIN_MOD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_W-1:0]    N,
  input  logic [FRAC_W-1:0] frac,
  input  logic [1:0]        order,
  output logic [N_W-1:0]    sdm_mpr_o,
  output logic              clko,
  output logic              clkob,
  output logic              sdm_qn,
  output logic              div_tick
);

  localparam int SW = N_W + 3;
  localparam logic signed [SW-1:0] MIN_S = SW'(MIN_MOD);
  localparam logic signed [SW-1:0] MAX_S = SW'((1 << N_W) - 1);

  // y spans -3..+4, so one bit beyond Y_W keeps +4 representable
  function automatic logic signed [Y_W:0] bit2s(input logic b);
    return $signed({{Y_W{1'b0}}, b});
  endfunction

  function automatic logic [N_W-1:0] sat_mod(input logic [N_W-1:0] n,
                                             input logic signed [Y_W:0] y);
    logic signed [SW-1:0] s;
    s = $signed({3'b000, n}) + $signed({{(SW-Y_W-1){y[Y_W]}}, y});
    if (s < MIN_S)      return N_W'(MIN_MOD);
    else if (s > MAX_S) return '1;
    else                return s[N_W-1:0];
  endfunction

  logic [N_W-1:0]        counter;
  logic                  run;
  logic                  bnd;
  logic signed [Y_W:0]   y_reg;
  logic signed [Y_W:0]   y_nxt;
  logic [N_W-1:0]        m_now;
  logic                  c1, c2, c3;
  logic                  c2_d, c3_d, c3_dd;
  logic [FRAC_W-1:0]     s1, s2, unused_s3;
  logic                  dith;

  // Inputs are only consumed on the boundary edge, so mid-period changes
  // are invisible until the next period starts.
  assign bnd   = (counter == '0);
  assign m_now = sat_mod(N, y_reg);

`ifdef SDM_DITHER_EN
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (bnd) begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign dith = lfsr[0];
`else
  assign dith = 1'b0;
`endif

  sdm_mash_stage #(.FRAC_W(FRAC_W)) u_stage1 (
    .clk(clk), .rst(rst), .en(bnd), .clr(order == ORD_INT),
    .addend(frac), .cin(dith), .acc_nxt(s1), .cout(c1)
  );

  sdm_mash_stage #(.FRAC_W(FRAC_W)) u_stage2 (
    .clk(clk), .rst(rst), .en(bnd), .clr(order < ORD_M11),
    .addend(s1), .cin(1'b0), .acc_nxt(s2), .cout(c2)
  );

  sdm_mash_stage #(.FRAC_W(FRAC_W)) u_stage3 (
    .clk(clk), .rst(rst), .en(bnd), .clr(order != ORD_M111),
    .addend(s2), .cin(1'b0), .acc_nxt(unused_s3), .cout(c3)
  );

  // Noise-shaping combiner; disabled stages already present zero carries.
  always_comb begin
    y_nxt = '0;
    case (order)
      ORD_M1:   y_nxt = bit2s(c1);
      ORD_M11:  y_nxt = bit2s(c1) + bit2s(c2) - bit2s(c2_d);
      ORD_M111: y_nxt = bit2s(c1) + bit2s(c2) - bit2s(c2_d)
                      + bit2s(c3) - bit2s(c3_d) - bit2s(c3_d) + bit2s(c3_dd);
      default:  y_nxt = '0;
    endcase
  end

  // Period boundary: load new modulus, advance modulator; otherwise count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter   <= '0;
      run       <= 1'b0;
      sdm_mpr_o <= '0;
      clko      <= 1'b0;
      sdm_qn    <= 1'b0;
      y_reg     <= '0;
      c2_d      <= 1'b0;
      c3_d      <= 1'b0;
      c3_dd     <= 1'b0;
    end else if (bnd) begin
      counter   <= m_now - 1'b1;
      run       <= 1'b1;
      sdm_mpr_o <= m_now;
      clko      <= (m_now - 1'b1) >= (m_now >> 1);
      sdm_qn    <= c1;
      y_reg     <= y_nxt;
      c2_d      <= c2;
      c3_d      <= c3;
      c3_dd     <= (order == ORD_M111) ? c3_d : 1'b0;
    end else begin
      counter   <= counter - 1'b1;
      clko      <= (counter - 1'b1) >= (sdm_mpr_o >> 1);
    end
  end

  assign clkob    = ~clko;
  assign div_tick = run & bnd & ~rst;

endmodule

// File: tb/tb_sdm_div_loop_p.sv
module tb_sdm_div_loop_p;

  localparam int N_W     = 6;
  localparam int FRAC_W  = 10;
  localparam int MIN_MOD = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_W-1:0]    N = 6'd31;
  logic [FRAC_W-1:0] frac = 10'd416;
  logic [1:0]        order = 2'd0;
  logic [N_W-1:0]    sdm_mpr_o;
  logic              clko, clkob, sdm_qn, div_tick;

  always #5 clk = ~clk;

  sdm_div_loop_p #(.N_W(N_W), .FRAC_W(FRAC_W), .MIN_MOD(MIN_MOD)) dut (
    .clk(clk), .rst(rst), .N(N), .frac(frac), .order(order),
    .sdm_mpr_o(sdm_mpr_o), .clko(clko), .clkob(clkob),
    .sdm_qn(sdm_qn), .div_tick(div_tick)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // reference model state
  int m_cnt = 0, m_run = 0, m_mpr = 0, m_qn = 0, m_clko = 0, m_y = 0;
  int a1 = 0, a2 = 0, a3 = 0, c2d = 0, c3d = 0, c3dd = 0;
  int lfsr = 1;
  int nb = 0;
  int exp_q[$];

  // observed statistics
  int sum_m, cnt_qn, min_m, max_m, sum64;
  bit prev_rst = 1'b1;
  bit prev_tick = 1'b0;

  task automatic clear_stats();
    sum_m = 0; cnt_qn = 0; min_m = 1000000; max_m = -1;
  endtask

  task automatic model_step();
    int m, t, c1, c2, c3, ny, cin;
    if (rst) begin
      m_cnt = 0; m_run = 0; m_mpr = 0; m_qn = 0; m_clko = 0; m_y = 0;
      a1 = 0; a2 = 0; a3 = 0; c2d = 0; c3d = 0; c3dd = 0; lfsr = 1;
    end else if (m_cnt == 0) begin
      m = int'(N) + m_y;
      if (m < MIN_MOD) m = MIN_MOD;
      if (m > 63) m = 63;
      c1 = 0; c2 = 0; c3 = 0; cin = 0;
`ifdef SDM_DITHER_EN
      cin  = lfsr & 1;
      lfsr = ((lfsr << 1) & 32'h7fff) | (((lfsr >> 14) ^ (lfsr >> 13)) & 1);
`endif
      if (order == 0) begin
        a1 = 0; a2 = 0; a3 = 0;
      end else begin
        t = a1 + int'(frac) + cin; c1 = t / 1024; a1 = t % 1024;
        if (order >= 2) begin t = a2 + a1; c2 = t / 1024; a2 = t % 1024; end
        else a2 = 0;
        if (order == 3) begin t = a3 + a2; c3 = t / 1024; a3 = t % 1024; end
        else a3 = 0;
      end
      case (order)
        2'd1:    ny = c1;
        2'd2:    ny = c1 + c2 - c2d;
        2'd3:    ny = c1 + c2 - c2d + c3 - 2 * c3d + c3dd;
        default: ny = 0;
      endcase
      c3dd = (order == 3) ? c3d : 0;
      c3d = c3; c2d = c2; m_y = ny;
      m_qn = c1; m_mpr = m; m_cnt = m - 1; m_run = 1;
      m_clko = (m_cnt >= m / 2) ? 1 : 0;
      exp_q.push_back(m * 2 + c1);
      nb++;
    end else begin
      m_cnt--;
      m_clko = (m_cnt >= m_mpr / 2) ? 1 : 0;
    end
  endtask

  task automatic cyc();
    bit bnd_dut;
    int e;
    @(posedge clk);
    model_step();
    #1;
    chk("clko", clko, m_clko);
    chk("clkob", clkob, !m_clko);
    chk("div_tick", div_tick, (m_run == 1 && m_cnt == 0 && !rst));
    bnd_dut = !rst && (prev_rst || prev_tick);
    if (bnd_dut) begin
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mpr", sdm_mpr_o, e / 2);
        chk("qn", sdm_qn, e % 2);
        sum_m  += int'(sdm_mpr_o);
        cnt_qn += int'(sdm_qn);
        if (int'(sdm_mpr_o) < min_m) min_m = int'(sdm_mpr_o);
        if (int'(sdm_mpr_o) > max_m) max_m = int'(sdm_mpr_o);
      end
    end
    prev_rst  = rst;
    prev_tick = div_tick;
  endtask

  task automatic run_periods(input int k);
    int target;
    target = nb + k;
    while (nb < target) cyc();
  endtask

  task automatic wait_cnt10();
    int guard;
    guard = 0;
    while (!(m_cnt == 10 && m_run == 1) && guard < 200) begin cyc(); guard++; end
    chk("wait_cnt10_bound", guard < 200, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mpr"}, sdm_mpr_o, 0);
    chk({tag, "_qn"}, sdm_qn, 0);
    chk({tag, "_clko"}, clko, 0);
    chk({tag, "_clkob"}, clkob, 1);
    chk({tag, "_tick"}, div_tick, 0);
  endtask

  initial begin
    int k;
    clear_stats();
    sum64 = 0;

    // integer mode
    rst = 1'b1; N = 6'd31; frac = 10'd416; order = 2'd0;
    repeat (3) cyc();
    check_reset_vals("rst");
    rst = 1'b0;
    clear_stats();
    run_periods(8);
    chk("int_min", min_m, 31);
    chk("int_max", max_m, 31);
    chk("int_qn", cnt_qn, 0);
    chk("int_drain", exp_q.size(), 0);

    // MASH-1 from reset
    rst = 1'b1; order = 2'd1;
    cyc();
    rst = 1'b0;
    clear_stats();
    run_periods(64);
    sum64 = sum_m;
    run_periods(960);
`ifndef SDM_DITHER_EN
    // 416 carries in 1024 updates; y lags one period, so the final carry
    // lands in period 1025 and the first 1024 periods hold 415 of them.
    chk("m1_sum", sum_m, 31 * 1024 + 415);
    chk("m1_qn_count", cnt_qn, 416);
`endif
    chk("m1_min", min_m, 31);
    chk("m1_max", max_m, 32);
    chk("m1_drain", exp_q.size(), 0);

    // MASH-1-1-1 from reset
    rst = 1'b1; order = 2'd3;
    cyc();
    rst = 1'b0;
    clear_stats();
    run_periods(1024);
`ifndef SDM_DITHER_EN
    chk("m111_sum_window", (sum_m >= 32156 && sum_m <= 32164), 1);
`endif
    chk("m111_min", min_m >= 28, 1);
    chk("m111_max", max_m <= 35, 1);

    // mid-period N/order change: current period keeps its length
    wait_cnt10();
    N = 6'd20; order = 2'd1;
    k = 0;
    do begin cyc(); k++; end while (!div_tick && k < 100);
    chk("glitch_len", k, 10);
    run_periods(1);
    clear_stats();
    run_periods(19);
    chk("glitch_min", min_m, 20);
    chk("glitch_max", max_m, 21);

    // saturation
    N = 6'd5; order = 2'd3; frac = 10'd1023;
    run_periods(1);
    clear_stats();
    run_periods(200);
    chk("sat_lo", min_m >= MIN_MOD, 1);
    N = 6'd63;
    run_periods(1);
    clear_stats();
    run_periods(40);
    chk("sat_hi_max", max_m, 63);
    chk("sat_hi_min", min_m >= 60, 1);
    chk("sat_drain", exp_q.size(), 0);

    // reset mid-period, then MASH-1 restarts identically
    N = 6'd31; frac = 10'd416; order = 2'd1;
    run_periods(2);
    wait_cnt10();
    rst = 1'b1;
    cyc();
    check_reset_vals("midrst");
    rst = 1'b0;
    exp_q.delete();
    clear_stats();
    run_periods(1);
    chk("midrst_first", sum_m, 31);
    run_periods(63);
    chk("midrst_repeat64", sum_m, sum64);
    cyc();
    chk("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
